// File: rtl/ima_pkg.sv
// rtl/ima_pkg.sv - shared state encoding, LFSR constants and line-length helpers for the line transmitter
package ima_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_SYNC,
        ST_BLACK_L,
        ST_ACTIVE,
        ST_BLACK_R,
        ST_TRAIL,
        ST_WAIT_ACK
    } ima_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci form, taps 16,14,13,11: feedback from bits 0,2,3,5, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
    endfunction

    // Sync + left black + active + right black + trailer.
    function automatic int line_len(input int bpn_l, input int read_pixel, input int bpn_r);
        return bpn_l + read_pixel + bpn_r + 2;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ima_lfsr16.sv
// rtl/ima_lfsr16.sv - 16-bit Fibonacci LFSR noise source, advances only when enabled
module ima_lfsr16
    import ima_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] q
);

    // Step the register once per enabled cycle; reset returns it to the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/ima_line_tx.sv
// rtl/ima_line_tx.sv - line framer: sync, noisy black borders, active pixels, trailer, sink handshake
module ima_line_tx
    import ima_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int BPN_L       = 100,
    parameter int READ_PIXEL  = 16,
    parameter int BPN_R       = 100,
    parameter int NOISE_BITS  = 3,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] black_level,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  dst_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] odata,
    output logic                  busy,
    output logic                  line_done,
    output logic                  err
);

    localparam int CNT_MAX = max2(max2(BPN_L, READ_PIXEL), max2(BPN_R, ACK_TIMEOUT));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    ima_state_e            state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [DATA_WIDTH-1:0] bl_q;
    logic                  bl_load;
    logic                  beat;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  done;
    logic                  set_err;
    logic                  lfsr_en;
    logic [15:0]           lfsr_q;
    logic [DATA_WIDTH:0]   noisy_sum;
    logic [DATA_WIDTH-1:0] noisy_black;

    ima_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .q     (lfsr_q)
    );

    // Black pixel value: latched level plus LFSR noise, clamped at full scale instead of wrapping.
    always_comb begin
        noisy_sum   = {1'b0, bl_q} + {{(DATA_WIDTH + 1 - NOISE_BITS){1'b0}}, lfsr_q[NOISE_BITS-1:0]};
        noisy_black = noisy_sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : noisy_sum[DATA_WIDTH-1:0];
    end

    assign s_ready = (state == ST_ACTIVE);
    assign busy    = (state != ST_IDLE);

    // Next-state and beat generation; each region's counter restarts at zero on entry.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bl_load   = 1'b0;
        beat      = 1'b0;
        beat_data = bl_q;
        done      = 1'b0;
        set_err   = 1'b0;
        lfsr_en   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_n = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (dst_ready) begin
                    state_n = ST_SYNC;
                    bl_load = 1'b1;
                    cnt_n   = '0;
                end
            end
            ST_SYNC: begin
                beat    = 1'b1;
                cnt_n   = '0;
                state_n = (BPN_L > 0) ? ST_BLACK_L : ST_ACTIVE;
            end
            ST_BLACK_L: begin
                beat      = 1'b1;
                beat_data = noisy_black;
                lfsr_en   = 1'b1;
                if (cnt == CNT_W'(BPN_L - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_ACTIVE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (s_valid) begin
                    beat      = 1'b1;
                    beat_data = s_data;
                    if (cnt == CNT_W'(READ_PIXEL - 1)) begin
                        cnt_n   = '0;
                        state_n = (BPN_R > 0) ? ST_BLACK_R : ST_TRAIL;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            ST_BLACK_R: begin
                beat      = 1'b1;
                beat_data = noisy_black;
                lfsr_en   = 1'b1;
                if (cnt == CNT_W'(BPN_R - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_TRAIL;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_TRAIL: begin
                beat    = 1'b1;
                done    = 1'b1;
                cnt_n   = '0;
                state_n = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (!dst_ready) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    cnt_n   = '0;
                    set_err = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State, counters and the registered pixel output; err is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bl_q      <= '0;
            o_valid   <= 1'b0;
            odata     <= '0;
            line_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            o_valid   <= beat;
            line_done <= done;
            if (bl_load) bl_q <= black_level;
            if (beat) odata <= beat_data;
            if (set_err) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ima_line_tx.sv
// tb/tb_ima_line_tx.sv - randomized self-checking bench for ima_line_tx against a line-level model
module tb_ima_line_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] black_level = 8'd16;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       dst_ready = 1'b1;

    logic       s_ready_a, o_valid_a, busy_a, line_done_a, err_a;
    logic [7:0] odata_a;
    logic       s_ready_b, o_valid_b, busy_b, line_done_b, err_b;
    logic [7:0] odata_b;

    int tests = 0;
    int fails = 0;

    int got_a[$];
    int got_b[$];
    int done_a[$];
    int done_b[$];

    logic [15:0] mlfsr_a;
    logic [15:0] mlfsr_b;

    always #5 clk = ~clk;

    ima_line_tx u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .black_level(black_level),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_a), .dst_ready(dst_ready),
        .o_valid(o_valid_a), .odata(odata_a), .busy(busy_a), .line_done(line_done_a), .err(err_a)
    );

    ima_line_tx #(.BPN_L(0), .READ_PIXEL(4), .BPN_R(0), .ACK_TIMEOUT(20)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .black_level(black_level),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b), .dst_ready(dst_ready),
        .o_valid(o_valid_b), .odata(odata_b), .busy(busy_b), .line_done(line_done_b), .err(err_b)
    );

    // Capture every emitted beat and the beat index at which line_done was seen.
    always @(negedge clk) begin
        if (o_valid_a) got_a.push_back(int'(odata_a));
        if (line_done_a) done_a.push_back(o_valid_a ? got_a.size() - 1 : -1);
        if (o_valid_b) got_b.push_back(int'(odata_b));
        if (line_done_b) done_b.push_back(o_valid_b ? got_b.size() - 1 : -1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] x);
        return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
    endfunction

    function automatic int black_val(input int bl, input logic [15:0] l);
        int s;
        s = bl + int'(l & 16'h0007);
        return (s > 255) ? 255 : s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        mlfsr_a = 16'hACE1;
        mlfsr_b = 16'hACE1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // gap: 0 = s_valid always high, 1 = toggle every cycle, 2 = random
    task automatic run_line(input int inst, input int bl, input int gap, input bit hold_rdy);
        int L, A, R, k, cyc, n_low;
        int data[$];
        int exp[$];
        logic [15:0] l;
        string nm;
        nm = (inst == 0) ? "a" : "b";
        if (inst == 0) begin L = 100; A = 16; R = 100; l = mlfsr_a; end
        else           begin L = 0;   A = 4;  R = 0;   l = mlfsr_b; end
        for (int i = 0; i < A; i++)
            data.push_back((gap == 0 && inst == 0) ? i : int'($urandom_range(0, 255)));
        exp.push_back(bl);
        for (int i = 0; i < L; i++) begin exp.push_back(black_val(bl, l)); l = model_step(l); end
        foreach (data[i]) exp.push_back(data[i]);
        for (int i = 0; i < R; i++) begin exp.push_back(black_val(bl, l)); l = model_step(l); end
        exp.push_back(bl);
        if (inst == 0) mlfsr_a = l; else mlfsr_b = l;

        got_a.delete(); got_b.delete(); done_a.delete(); done_b.delete();
        black_level = 8'(bl);
        dst_ready = 1'b1;
        if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        k = 0;
        cyc = 0;
        while (k < A && cyc < 3000) begin
            s_valid = (gap == 0) ? 1'b1 : (gap == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            s_data = 8'(data[k]);
            if (s_valid && ((inst == 0) ? s_ready_a : s_ready_b)) k++;
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        check({"active_accepted_", nm}, k, A);
        cyc = 0;
        while (((inst == 0) ? done_a.size() : done_b.size()) == 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({"line_done_seen_", nm}, (inst == 0) ? done_a.size() : done_b.size(), 1);
        @(negedge clk);
        if (!hold_rdy) begin
            dst_ready = 1'b0;
            repeat (2) @(negedge clk);
            check({"busy_after_ack_", nm}, (inst == 0) ? busy_a : busy_b, 0);
            check({"err_after_ack_", nm}, (inst == 0) ? err_a : err_b, 0);
        end
        if (inst == 0) begin
            check("beats_a", got_a.size(), exp.size());
            if (got_a.size() == exp.size()) begin
                foreach (exp[i]) check($sformatf("beat_a[%0d]", i), got_a[i], exp[i]);
                if (bl == 254) begin
                    n_low = 0;
                    for (int i = 1; i <= L; i++) if (got_a[i] < 254) n_low++;
                    for (int i = L + A + 1; i <= L + A + R; i++) if (got_a[i] < 254) n_low++;
                    check("black_saturated_a", n_low, 0);
                end
            end
            if (done_a.size() > 0) check("done_index_a", done_a[0], exp.size() - 1);
        end else begin
            check("beats_b", got_b.size(), exp.size());
            if (got_b.size() == exp.size())
                foreach (exp[i]) check($sformatf("beat_b[%0d]", i), got_b[i], exp[i]);
            if (done_b.size() > 0) check("done_index_b", done_b[0], exp.size() - 1);
        end
    endtask

    initial begin
        int first, cyc, n0;
        mlfsr_a = 16'hACE1;
        mlfsr_b = 16'hACE1;
        repeat (2) @(negedge clk);
        check("reset_o_valid", o_valid_a, 0);
        check("reset_odata", odata_a, 0);
        check("reset_s_ready", s_ready_a, 0);
        check("reset_busy", busy_a, 0);
        check("reset_line_done", line_done_a, 0);
        check("reset_err", err_a, 0);
        do_reset();

        run_line(0, 16, 0, 1'b0);
        run_line(0, 254, 1, 1'b0);
        for (int i = 0; i < 3; i++) run_line(0, int'($urandom_range(0, 255)), 2, 1'b0);
        run_line(1, 255, 0, 1'b0);
        run_line(1, int'($urandom_range(0, 255)), 2, 1'b0);

        // Sink never acknowledges: timeout must raise err and return to idle.
        run_line(0, 40, 2, 1'b1);
        repeat (990) @(negedge clk);
        check("timeout_err_early", err_a, 0);
        check("timeout_busy_early", busy_a, 1);
        repeat (40) @(negedge clk);
        check("timeout_err", err_a, 1);
        check("timeout_busy", busy_a, 0);

        // New start with sink not ready: parks in WAIT_RDY, first beat 2 cycles after the rise.
        dst_ready = 1'b0;
        got_a.delete();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (50) @(negedge clk);
        check("wait_rdy_busy", busy_a, 1);
        check("wait_rdy_no_beats", got_a.size(), 0);
        check("err_sticky", err_a, 1);
        s_valid = 1'b1;
        s_data = 8'($urandom_range(0, 255));
        dst_ready = 1'b1;
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (o_valid_a && first < 0) first = i;
        end
        check("first_beat_latency", first, 2);

        // Reset in the middle of the line aborts it.
        cyc = 0;
        while (got_a.size() < 120 && cyc < 400) begin
            @(negedge clk);
            #1;
            s_data = 8'($urandom_range(0, 255));
            cyc++;
        end
        check("reached_beat_120", got_a.size(), 120);
        rst_n = 1'b0;
        n0 = got_a.size();
        @(negedge clk);
        check("midline_rst_o_valid", o_valid_a, 0);
        check("midline_rst_odata", odata_a, 0);
        check("midline_rst_busy", busy_a, 0);
        check("midline_rst_s_ready", s_ready_a, 0);
        check("midline_rst_err", err_a, 0);
        repeat (2) @(negedge clk);
        check("midline_rst_no_beats", got_a.size(), n0);
        s_valid = 1'b0;
        mlfsr_a = 16'hACE1;
        mlfsr_b = 16'hACE1;
        rst_n = 1'b1;
        @(negedge clk);
        run_line(0, 16, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ima_line_tx.md
IMA_LINE_TX -- requirements
Module: ima_line_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter BPN_L, default 100, count of left black pixels per line.
REQ-003 SHALL have parameter READ_PIXEL, default 16, count of active pixels per line.
REQ-004 SHALL have parameter BPN_R, default 100, count of right black pixels per line.
REQ-005 SHALL have parameter NOISE_BITS, default 3, LSB width of pseudo-random noise added to black pixels.
REQ-006 SHALL have parameter ACK_TIMEOUT, default 1023, maximum cycles to wait for the sink to begin readout.
REQ-007 SHALL have port clk, input, 1, clock.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, single-cycle request to send one line.
REQ-010 SHALL have port black_level, input, DATA_WIDTH, base value for black pixels, sampled at line start.
REQ-011 SHALL have ports s_valid (input, 1), s_data (input, DATA_WIDTH) and s_ready (output, 1), the upstream active-pixel stream.
REQ-012 SHALL have port dst_ready, input, 1, the sink's line-ready flag (high means idle and accepting a new line).
REQ-013 SHALL have ports o_valid (output, 1) and odata (output, DATA_WIDTH), the pixel stream to the sink, with no backpressure.
REQ-014 SHALL have ports busy (output, 1), line_done (output, 1-cycle pulse) and err (output, 1, sticky).

Function
REQ-015 Line layout SHALL be LINE_LEN = BPN_L+READ_PIXEL+BPN_R+2 valid beats: slot 0 sync, slots 1..BPN_L left black, next READ_PIXEL active, next BPN_R right black, last slot trailer.
REQ-016 The sync and trailer beats SHALL carry black_level (unnoised).
REQ-017 Black beats SHALL carry min(black_level + (lfsr & (2^NOISE_BITS-1)), 2^DATA_WIDTH-1), i.e. saturating addition.
REQ-018 The LFSR SHALL be a 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 16'hACE1 after reset, advancing once per black beat only.
REQ-019 FSM states SHALL be IDLE, WAIT_RDY, SYNC, BLACK_L, ACTIVE, BLACK_R, TRAIL, WAIT_ACK.
REQ-020 IDLE: start SHALL go to WAIT_RDY; start SHALL be ignored in any other state.
REQ-021 WAIT_RDY: dst_ready high SHALL go to SYNC and latch black_level.
REQ-022 SYNC, BLACK_L, BLACK_R and TRAIL SHALL emit exactly one beat per cycle (o_valid=1), with a beat counter advancing state at the region boundary.
REQ-023 ACTIVE: s_ready SHALL be 1 only in this state; a beat SHALL be emitted (odata=s_data) exactly when s_valid&s_ready; with s_valid low, o_valid SHALL be 0 and the counter SHALL hold.
REQ-024 Output SHALL be registered: beat data appears at odata one cycle after the state/handshake that produced it.
REQ-025 After TRAIL the FSM SHALL enter WAIT_ACK, pulse line_done with the final beat, and wait for dst_ready low.
REQ-026 WAIT_ACK: dst_ready low SHALL return to IDLE; if ACK_TIMEOUT cycles elapse with dst_ready high, the FSM SHALL set err and return to IDLE.
REQ-027 busy SHALL be high in every state except IDLE.
REQ-028 If BPN_L or BPN_R is 0, the corresponding state SHALL be skipped with no beat emitted.
REQ-029 err SHALL clear only on reset.

Reset
REQ-030 On rst_n low, state SHALL be IDLE, counters 0, LFSR at seed, and o_valid, odata, s_ready, busy, line_done and err all 0.
REQ-031 Reset asserted mid-line SHALL abort the line immediately, with no further beats emitted.

Structure
REQ-032 State encoding, the LFSR seed/taps and the LINE_LEN function SHALL live in the shared package ima_pkg.
REQ-033 The LFSR SHALL be a sub-module ima_lfsr16 (ports clk, rst_n, en, q).

Verification
REQ-034 Defaults, black_level=16, dst_ready=1, s_valid always 1, data 0..15, start pulse -> 218 beats: first 16, 100 beats in 16..23, 0..15 in order, 100 beats in 16..23, last 16; line_done pulses with the last beat.
REQ-035 black_level=8'hFE, NOISE_BITS=3 -> every black beat is 8'hFE or 8'hFF, never wrapping to 0..5.
REQ-036 s_valid toggled every other cycle during ACTIVE -> o_valid has gaps, 16 active beats total, order preserved, no duplicates.
REQ-037 dst_ready held high after line end for 1023 cycles -> err=1, FSM in IDLE, busy=0; a subsequent start waits in WAIT_RDY.
REQ-038 dst_ready=0 at start, rising 50 cycles later -> first beat emitted 2 cycles after the rise, none earlier.
REQ-039 rst_n pulsed low at beat 120 -> o_valid=0 on the next cycle, outputs at reset values, LFSR reseeded.
